// File: rtl/tqv_periph_bus_master.sv
// TinyQV peripheral bus initiator: one bus access per command, response on a valid/ready port.
// Latency: write 2 cycles, read 1+n, timeout 1+TIMEOUT, rejected command 1; the response holds until rsp_ready.
module tqv_periph_bus_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        rsp_error,

    output logic [5:0]  address,
    output logic [31:0] data_out,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_in,
    input  logic        data_ready
);

    if (TIMEOUT < 1 || TIMEOUT > 255 || (64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_param_check
        $error("tqv_periph_bus_master: TIMEOUT must be 1..255 and fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0]       STROBE_IDLE = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic [5:0]  address_q, address_d;
    logic [31:0] data_out_q, data_out_d;
    logic [1:0]  wr_n_q, wr_n_d;
    logic [1:0]  rd_n_q, rd_n_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tmo_q, tmo_d;
    logic        err_q, err_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        cmd_bad;

    function automatic logic [31:0] size_mask(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {24'h0, d[7:0]};
            2'b01:   return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign cmd_bad = (cmd_size == 2'b11)
                   | ((cmd_size == 2'b01) & cmd_addr[0])
                   | ((cmd_size == 2'b10) & (cmd_addr[1:0] != 2'b00));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        address_d  = address_q;
        data_out_d = '0;
        wr_n_d     = STROBE_IDLE;
        rd_n_d     = STROBE_IDLE;
        rdata_d    = rdata_q;
        tmo_d      = tmo_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_rdy_q) begin
                    size_d  = cmd_size;
                    rdata_d = '0;
                    tmo_d   = 1'b0;
                    err_d   = 1'b0;
                    if (cmd_bad) begin
                        // Rejected commands never touch the bus, address included.
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        address_d = cmd_addr;
                        cnt_d     = '0;
                        if (cmd_write) begin
                            data_out_d = size_mask(cmd_size, cmd_wdata);
                            wr_n_d     = cmd_size;
                            state_d    = ST_WRITE;
                        end else begin
                            rd_n_d  = cmd_size;
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_READ: begin
                if (data_ready) begin
                    rdata_d = size_mask(size_q, data_in);
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    rd_n_d = size_q;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    tmo_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered so cmd_ready stays low while rst_n is held and rises the cycle after release.
        cmd_rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            size_q     <= 2'b00;
            address_q  <= '0;
            data_out_q <= '0;
            wr_n_q     <= STROBE_IDLE;
            rd_n_q     <= STROBE_IDLE;
            rdata_q    <= '0;
            tmo_q      <= 1'b0;
            err_q      <= 1'b0;
            cmd_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            address_q  <= address_d;
            data_out_q <= data_out_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            cmd_rdy_q  <= cmd_rdy_d;
        end
    end

    assign cmd_ready    = cmd_rdy_q;
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_rdata    = rdata_q;
    assign rsp_timeout  = tmo_q;
    assign rsp_error    = err_q;
    assign address      = address_q;
    assign data_out     = data_out_q;
    assign data_write_n = wr_n_q;
    assign data_read_n  = rd_n_q;

endmodule

// File: tb/tb_tqv_periph_bus_master.sv
// Bench for tqv_periph_bus_master: vector table with a response scoreboard, plus reset sequences.
module tb_tqv_periph_bus_master;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_size = 2'b00;
    logic [5:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        rsp_error;
    logic [5:0]  address;
    logic [31:0] data_out;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_in = '0;
    logic        data_ready = 1'b0;

    always #5 clk = ~clk;

    tqv_periph_bus_master #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout), .rsp_error(rsp_error),
        .address(address), .data_out(data_out), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_in(data_in), .data_ready(data_ready)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          rdy_at;     // READ cycle in which data_ready rises; 0 = never
        logic [31:0] din;
        int          hold;       // cycles rsp_ready is held low once the response appears
        logic [31:0] exp_rdata;
        logic [31:0] exp_dout;
        logic        exp_err;
        logic        exp_tmo;
        int          exp_lat;
        int          exp_wr_cyc;
        int          exp_rd_cyc;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];
    vec_t sb [$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int   lat, wr_cyc, rd_cyc, viol, hold_viol;
        logic [31:0] dout_seen;
        vec_t e;
        lat = 0; wr_cyc = 0; rd_cyc = 0; viol = 0; hold_viol = 0; dout_seen = '0;

        chk($sformatf("v%0d_cmd_ready", idx), {31'b0, cmd_ready}, 32'd1);
        cmd_write = v.wr; cmd_size = v.size; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_valid = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 cmd_valid = 1'b0;

        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                break;
            end
            if (data_write_n != 2'b11) begin
                wr_cyc++;
                dout_seen = data_out;
                if (data_write_n != v.size || address != v.addr) viol++;
            end else if (data_out != 32'h0) begin
                viol++;
            end
            if (data_read_n != 2'b11) begin
                rd_cyc++;
                if (data_read_n != v.size || address != v.addr) viol++;
                if (data_write_n != 2'b11) viol++;
            end
            data_ready = (data_read_n != 2'b11) && (rd_cyc == v.rdy_at);
            data_in    = data_ready ? v.din : 32'(~v.din);
        end
        data_ready = 1'b0;

        if (lat == 0) begin
            checks++; failures++;
            $display("FAIL v%0d_rsp_wait: no rsp_valid within 40 cycles", idx);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL v%0d_scoreboard: response with empty queue", idx);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d_rdata", idx),   rsp_rdata, e.exp_rdata);
        chk($sformatf("v%0d_error", idx),   {31'b0, rsp_error}, {31'b0, e.exp_err});
        chk($sformatf("v%0d_timeout", idx), {31'b0, rsp_timeout}, {31'b0, e.exp_tmo});
        chk($sformatf("v%0d_latency", idx), lat, e.exp_lat);
        chk($sformatf("v%0d_wr_cycles", idx), wr_cyc, e.exp_wr_cyc);
        chk($sformatf("v%0d_rd_cycles", idx), rd_cyc, e.exp_rd_cyc);
        chk($sformatf("v%0d_data_out", idx), dout_seen, e.exp_dout);
        if (data_write_n != 2'b11 || data_read_n != 2'b11 || data_out != 32'h0 || cmd_ready) viol++;
        chk($sformatf("v%0d_bus_rules", idx), viol, 0);

        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || rsp_rdata !== e.exp_rdata ||
                rsp_error !== e.exp_err || rsp_timeout !== e.exp_tmo ||
                data_write_n != 2'b11 || data_read_n != 2'b11) hold_viol++;
        end
        if (v.hold > 0) chk($sformatf("v%0d_hold_stable", idx), hold_viol, 0);

        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_rsp_released", idx), {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        //             wr    size   addr   wdata         rdy din           hold exp_rdata     exp_dout      err   tmo  lat wr rd
        vecs[0]  = '{1'b1, 2'b10, 6'h00, 32'h12345678, 0,  32'h0,        0, 32'h0,        32'h12345678, 1'b0, 1'b0, 2,  1, 0};
        vecs[1]  = '{1'b0, 2'b01, 6'h02, 32'h0,        1,  32'hABCD1234, 5, 32'h00001234, 32'h0,        1'b0, 1'b0, 2,  0, 1};
        vecs[2]  = '{1'b0, 2'b00, 6'h05, 32'h0,        4,  32'hFFFFFF5A, 0, 32'h0000005A, 32'h0,        1'b0, 1'b0, 5,  0, 4};
        vecs[3]  = '{1'b0, 2'b10, 6'h08, 32'h0,        0,  32'h0,        0, 32'h0,        32'h0,        1'b0, 1'b1, 17, 0, 16};
        vecs[4]  = '{1'b0, 2'b10, 6'h02, 32'h0,        1,  32'h55555555, 0, 32'h0,        32'h0,        1'b1, 1'b0, 1,  0, 0};
        vecs[5]  = '{1'b1, 2'b11, 6'h00, 32'hFFFFFFFF, 0,  32'h0,        0, 32'h0,        32'h0,        1'b1, 1'b0, 1,  0, 0};
        vecs[6]  = '{1'b1, 2'b00, 6'h3F, 32'hAABBCCDD, 0,  32'h0,        0, 32'h0,        32'h000000DD, 1'b0, 1'b0, 2,  1, 0};
        vecs[7]  = '{1'b1, 2'b01, 6'h11, 32'h11223344, 0,  32'h0,        0, 32'h0,        32'h0,        1'b1, 1'b0, 1,  0, 0};
        vecs[8]  = '{1'b1, 2'b01, 6'h22, 32'h11223344, 0,  32'h0,        0, 32'h0,        32'h00003344, 1'b0, 1'b0, 2,  1, 0};
        vecs[9]  = '{1'b0, 2'b10, 6'h3C, 32'h0,        2,  32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 3,  0, 2};
        vecs[10] = '{1'b0, 2'b00, 6'h07, 32'h0,        16, 32'h12345687, 3, 32'h00000087, 32'h0,        1'b0, 1'b0, 17, 0, 16};

        // Reset held with a command pending
        rst_n = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 2'b10; cmd_addr = 6'h04; cmd_wdata = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_strobes", {28'b0, data_write_n, data_read_n}, 32'h0000000F);
        chk("rst_address", {26'b0, address}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_rsp_fields", {rsp_rdata[29:0], rsp_error, rsp_timeout}, 32'd0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < NV; i++) run_txn(i, vecs[i]);

        // Reset asserted in the middle of a read
        chk("midrd_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        cmd_write = 1'b0; cmd_size = 2'b10; cmd_addr = 6'h10; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrd_strobe_active", {30'b0, data_read_n}, 32'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrd_strobe_idle", {30'b0, data_read_n}, 32'd3);
        chk("midrd_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrd_address", {26'b0, address}, 32'd0);
        @(negedge clk);
        chk("midrd_cmd_ready_low", {31'b0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (rsp_valid || data_read_n != 2'b11) seen++;
            end
            chk("midrd_no_response", seen, 0);
        end
        chk("midrd_scoreboard_empty", sb.size(), 0);

        run_txn(NV, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/tqv_periph_bus_master.md
Name: tqv_periph_bus_master

Overview:
- Initiator for the TinyQV peripheral bus, i.e. the CPU-side end of the address/data_write_n/data_read_n/data_ready interface that user peripherals respond to.
- Accepts single-transaction commands on a valid/ready port and drives one bus access per command. Returns read data, or a timeout/error status, on a valid/ready response port.
- Used to drive peripherals from test harnesses and non-CPU hosts (e.g. a UART debug bridge) without the core.

Parameters:
- TIMEOUT, 16, maximum number of cycles a read strobe stays asserted waiting for data_ready (legal range 1..255).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  project clock (nominally 64 MHz)
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_size  input  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
- cmd_addr  input  6  peripheral byte address
- cmd_wdata  input  32  write data, low-aligned
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_rdata  output  32  read data, zero-extended to the access size; 0 for writes, errors and timeouts
- rsp_timeout  output  1  read ended without data_ready
- rsp_error  output  1  command rejected (illegal size or misaligned address); no bus activity occurred
- address  output  6  bus address to the peripheral
- data_out  output  32  bus write data (connects to the peripheral data_in)
- data_write_n  output  2  11 = idle, otherwise the size code
- data_read_n  output  2  11 = idle, otherwise the size code
- data_in  input  32  bus read data (from the peripheral data_out)
- data_ready  input  1  peripheral read data valid

Behaviour:

States:
- IDLE, WRITE, READ, RESP. All outputs are registered, or decoded from registered state only. No combinational path from data_ready or rsp_ready to any output.

Reset (rst_n low at a clock edge):
- State goes to IDLE; counter = 0.
- Outputs: cmd_ready = 0 during reset, 1 from the first cycle after release. rsp_valid, rsp_timeout and rsp_error are 0. rsp_rdata = 0, address = 0, data_out = 0, data_write_n = data_read_n = 11.
- Reset mid-transaction abandons the transaction. Strobes return to 11 at that same edge and no response is produced.

IDLE:
- cmd_ready = 1.
- On cmd_valid & cmd_ready, latch write, size, addr and wdata.
- Validate:
  - size == 11 is illegal.
  - size 01 with addr[0] = 1 is misaligned.
  - size 10 with addr[1:0] != 00 is misaligned.
- An illegal or misaligned command goes directly to RESP with rsp_error = 1, rsp_rdata = 0. No strobe is asserted.
- Otherwise go to WRITE or READ.
- cmd_ready = 0 in every state except IDLE.

WRITE (exactly 1 cycle):
- address = latched addr.
- data_out = wdata masked to the size (upper bytes 0).
- data_write_n = size.
- Then go to RESP with rsp_rdata = 0, timeout = 0, error = 0.

READ:
- address = latched addr; data_read_n = size held continuously.
- Each cycle, if data_ready = 1:
  - capture data_in masked to the size (8-bit: bits 31:8 = 0; 16-bit: bits 31:16 = 0);
  - go to RESP.
- Otherwise the counter increments. If data_ready has not been seen in TIMEOUT cycles of READ, go to RESP with rsp_timeout = 1, rsp_rdata = 0.
- The counter clears on entry to READ.
- data_write_n stays 11 throughout a read.

RESP:
- rsp_valid = 1, all response fields stable, bus strobes 11.
- On rsp_ready, go to IDLE at the next edge.
- A new command can be accepted at the earliest one cycle after the response handshake (no overlap).

Latency:
- Command accepted at edge k; strobe asserted during cycle k+1.
- A write, or a read with data_ready already high, gives rsp_valid at k+2.
- A read answered in its n-th READ cycle gives rsp_valid at k+1+n.
- A timeout gives rsp_valid at k+1+TIMEOUT.
- An error gives rsp_valid at k+1.

Bus hold rules:
- address holds its last value outside active states.
- data_out = 0 outside WRITE.
- Write and read strobes are never asserted together.

Test Plan:
- Reset: hold rst_n low 3 cycles while cmd_valid = 1 -> strobes 11, rsp_valid = 0, cmd_ready = 0; cmd_ready = 1 on the first cycle after release.
- 32-bit write: addr 0x00, wdata 0x12345678 -> data_write_n = 10 for exactly one cycle with address = 0x00, data_out = 0x12345678; rsp_valid at k+2 with rdata = 0, error = 0, timeout = 0.
- 16-bit read: addr 0x02, model drives data_ready = 1 with data_in = 0xABCD1234 -> data_read_n = 01 for one cycle; rsp_rdata = 0x00001234.
- Slow responder: 8-bit read at addr 0x05, data_ready asserted in the 4th READ cycle with data_in = 0xFFFFFF5A -> data_read_n = 00 for 4 cycles; rsp_rdata = 0x0000005A; rsp_valid at k+5.
- Timeout and error:
  - Read with data_ready stuck at 0, TIMEOUT = 16 -> 16 strobe cycles, then rsp_timeout = 1, rdata = 0.
  - 32-bit read at addr 0x02 -> rsp_error = 1 at k+1, no strobe.
  - size = 11 -> rsp_error = 1 at k+1, no strobe.
- Backpressure and reset mid-read:
  - Hold rsp_ready = 0 for 5 cycles -> response fields stable, cmd_ready = 0.
  - Assert rst_n low during READ -> data_read_n = 11 at the next edge and no response appears.
